stream_demux1to2: RTL
=====================

STREAM_DEMUX1TO2 -- requirements
Module: stream_demux1to2

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 8, the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 The block SHALL have port in_data, input, DATA_WIDTH bits: the upstream payload.
REQ-007 The block SHALL have port sel, input, 1 bit: destination of the upstream word (0 = port 0, 1 = port 1).
REQ-008 The block SHALL have ports out0_valid (output, 1 bit), out0_ready (input, 1 bit) and out0_data (output, DATA_WIDTH bits): destination 0 stream.
REQ-009 The block SHALL have ports out1_valid (output, 1 bit), out1_ready (input, 1 bit) and out1_data (output, DATA_WIDTH bits): destination 1 stream.
REQ-010 The block SHALL have ports cnt0 and cnt1, outputs, 16 bits each: transfer counters, present only when DEMUX_CNT_EN is defined.

Function
REQ-011 A transfer SHALL occur on any port in a cycle where its valid and ready are both 1.
REQ-012 Each output port SHALL have a one-entry holding register, with state EMPTY (outN_valid=0) or FULL (outN_valid=1).
REQ-013 in_ready SHALL be the combinational value (sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready)).
REQ-014 An accepted word SHALL be loaded into the register selected by sel; the selected port's valid SHALL be 1 from the next cycle, giving 1-cycle latency.
REQ-015 Transition EMPTY->FULL SHALL occur on load without drain, and FULL->EMPTY on drain without load.
REQ-016 Simultaneous drain and load on the same port SHALL keep the port FULL and replace the data, with no bubble.
REQ-017 The non-selected port SHALL drain independently in the same cycle as a load to the other port.
REQ-018 outN_data SHALL hold stable while outN_valid=1 and outN_ready=0.
REQ-019 Upstream SHALL hold in_data and sel stable while in_valid=1 and in_ready=0; the block SHALL NOT check this rule.
REQ-020 A word SHALL NOT be duplicated, dropped or delivered to the non-selected port.
REQ-021 With in_valid=0, no register SHALL load, regardless of sel.

Reset
REQ-022 rst=1 SHALL immediately force out0_valid=0, out1_valid=0, out0_data=0, out1_data=0 and (if compiled) cnt0=0, cnt1=0, independent of clk.
REQ-023 Words held when reset asserts, including mid-transfer, SHALL be discarded.
REQ-024 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 With macro DEMUX_CNT_EN defined, cnt0 and cnt1 SHALL each increment by 1 per completed transfer on out0 and out1 respectively, wrapping 16'hFFFF->0.
REQ-026 Without DEMUX_CNT_EN, the cnt0 and cnt1 ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then in_valid=1, sel=0, in_data=8'hA5, both readys=1 -> next cycle out0_valid=1, out0_data=A5, out1_valid=0.
REQ-028 out1_ready=0, send 8'h11 with sel=1, then 8'h22 with sel=1 -> in_ready=0 on the second word, out1_data stays 11; raise out1_ready -> 11 then 22 delivered, no loss.
REQ-029 Port 0 FULL with out0_ready=1, new word 8'h33 with sel=0 in the same cycle -> out0_valid stays 1, out0_data=33 next cycle.
REQ-030 Alternate sel 0/1 over 256 words with random readys -> scoreboard shows per-port order preserved, no duplicates, no misroutes.
REQ-031 Assert rst while both ports are FULL -> both valids 0 within the same cycle, no stale delivery after release.
REQ-032 With DEMUX_CNT_EN, complete 65537 transfers on out0 -> cnt0=1 and cnt1=0.

Source files
------------

// File: rtl/stream_demux1to2.sv
// One-to-two stream demultiplexer with a one-entry holding register per output.
// Define DEMUX_CNT_EN to add the 16-bit per-port transfer counters cnt0/cnt1.
module stream_demux1to2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  sel,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]           cnt0,
    output logic [15:0]           cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                r_st0;
    state_t                r_st1;
    state_t                w_st0_nxt;
    state_t                w_st1_nxt;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  w_ld0;
    logic                  w_ld1;
    logic                  w_dr0;
    logic                  w_dr1;

    assign out0_valid = (r_st0 == FULL);
    assign out1_valid = (r_st1 == FULL);
    assign out0_data  = r_data0;
    assign out1_data  = r_data1;

    // A slot can take a word when empty or when it is being drained this cycle.
    assign in_ready = sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready);

    assign w_ld0 = in_valid & in_ready & ~sel;
    assign w_ld1 = in_valid & in_ready &  sel;
    assign w_dr0 = out0_valid & out0_ready;
    assign w_dr1 = out1_valid & out1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st0 <= EMPTY;
            r_st1 <= EMPTY;
        end else begin
            r_st0 <= w_st0_nxt;
            r_st1 <= w_st1_nxt;
        end
    end

    always_comb begin
        w_st0_nxt = r_st0;
        w_st1_nxt = r_st1;
        case (r_st0)
            EMPTY:   if (w_ld0) w_st0_nxt = FULL;
            FULL:    if (w_dr0 && !w_ld0) w_st0_nxt = EMPTY;
            default: w_st0_nxt = EMPTY;
        endcase
        case (r_st1)
            EMPTY:   if (w_ld1) w_st1_nxt = FULL;
            FULL:    if (w_dr1 && !w_ld1) w_st1_nxt = EMPTY;
            default: w_st1_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_ld0) r_data0 <= in_data;
            if (w_ld1) r_data1 <= in_data;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_dr0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_dr1) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule
